// File: rtl/nios2_system_cpu_oci_dct_capture.sv
// nios2_system_cpu_oci_dct_capture: OCI DCT capture FIFO with valid/ready readout and end-of-test drain; OCI_CAPTURE_TIMESTAMP_EN adds a per-word timestamp
module nios2_system_cpu_oci_dct_capture #(
  parameter int DATA_W = 30,
  parameter int CNT_W  = 4,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16,
`ifdef OCI_CAPTURE_TIMESTAMP_EN
  localparam int WW = TS_W + DATA_W
`else
  localparam int WW = DATA_W + 0 * TS_W
`endif
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [DATA_W-1:0]       dct_buffer,
  input  logic [CNT_W-1:0]        dct_count,
  input  logic                    test_ending,
  input  logic                    test_has_ended,
  input  logic                    rd_ready,
  output logic                    rd_valid,
  output logic [WW-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic [7:0]              drop_count,
  output logic                    done
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] prev_q, prev_d;
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic overflow_q, overflow_d;
  logic [7:0] drop_q, drop_d;
  logic [WW-1:0] mem_q [DEPTH];
  logic [WW-1:0] wdata;
  logic empty, full, ev, pop, push, drop;
`ifdef OCI_CAPTURE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d;
  // free-running cycle stamp stored alongside each capture
  always_comb begin
    ts_d = ts_q + TS_W'(1);
    wdata = {ts_q, dct_buffer};
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ts_q <= '0;
    else ts_q <= ts_d;
`else
  assign wdata = dct_buffer;
`endif
  // capture detection, push/pop arbitration and drop accounting
  always_comb begin
    empty = wr_q == rd_q;
    full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    ev = (state_q == RUN) && (dct_count != prev_q) && (dct_count != '0);
    pop = !empty && rd_ready;
    push = ev && (!full || pop);
    drop = ev && full && !pop;
    prev_d = dct_count;
    wr_d = wr_q + (AW+1)'(push);
    rd_d = rd_q + (AW+1)'(pop);
    overflow_d = overflow_q | drop;
    drop_d = drop_q + 8'(drop && drop_q != 8'hff);
  end
  // end-of-test sequencing; drain completion uses the post-update pointers
  always_comb
    state_d = (state_q == RUN && (test_ending || test_has_ended)) ? DRAIN :
              (state_q == DRAIN && test_has_ended && wr_d == rd_d) ? DONE : state_q;
  // outputs derived only from registered state and the registered read pointer
  always_comb begin
    rd_valid = !empty;
    rd_data = empty ? '0 : mem_q[rd_q[AW-1:0]];
    level = wr_q - rd_q;
    overflow = overflow_q;
    drop_count = drop_q;
    done = state_q == DONE;
  end
  // control state with asynchronous clear so reset discards contents at once
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= RUN;
      prev_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      overflow_q <= 1'b0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      prev_q <= prev_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      overflow_q <= overflow_d;
      drop_q <= drop_d;
    end
  // storage array; contents are qualified by the pointers so need no reset
  always_ff @(posedge clk)
    if (push) mem_q[wr_q[AW-1:0]] <= wdata;
endmodule

// File: tb/tb_nios2_system_cpu_oci_dct_capture.sv
// tb_nios2_system_cpu_oci_dct_capture: randomized and directed checks against a queue-based reference model
module tb_nios2_system_cpu_oci_dct_capture;
  localparam int DATA_W = 30, CNT_W = 4, DEPTH = 16, TS_W = 16;
`ifdef OCI_CAPTURE_TIMESTAMP_EN
  localparam int WW = TS_W + DATA_W;
`else
  localparam int WW = DATA_W;
`endif
  logic clk = 0, reset_n = 0;
  logic [DATA_W-1:0] dct_buffer = '0;
  logic [CNT_W-1:0] dct_count = '0;
  logic test_ending = 0, test_has_ended = 0, rd_ready = 0;
  logic rd_valid, overflow, done;
  logic [WW-1:0] rd_data;
  logic [$clog2(DEPTH):0] level;
  logic [7:0] drop_count;
  int n_chk = 0, n_pass = 0;
  logic [WW-1:0] q[$];
  bit m_ovf;
  int m_drop, m_state;
  logic [CNT_W-1:0] m_prev;
  logic [TS_W-1:0] m_ts;
  always #5 clk = ~clk;
  nios2_system_cpu_oci_dct_capture #(.DATA_W(DATA_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk(clk), .reset_n(reset_n), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .test_ending(test_ending), .test_has_ended(test_has_ended), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .level(level), .overflow(overflow),
    .drop_count(drop_count), .done(done));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic check_outs(input string ph);
    check({ph, ".rd_valid"}, 64'(rd_valid), 64'(q.size() != 0));
    check({ph, ".rd_data"}, 64'(rd_data), q.size() != 0 ? 64'(q[0]) : 64'd0);
    check({ph, ".level"}, 64'(level), 64'(q.size()));
    check({ph, ".overflow"}, 64'(overflow), 64'(m_ovf));
    check({ph, ".drop_count"}, 64'(drop_count), 64'(m_drop));
    check({ph, ".done"}, 64'(done), 64'(m_state == 2));
  endtask
  task automatic model_reset();
    q.delete();
    m_ovf = 0;
    m_drop = 0;
    m_state = 0;
    m_prev = '0;
    m_ts = '0;
  endtask
  task automatic step(input string ph, input logic [DATA_W-1:0] d, input logic [CNT_W-1:0] c,
                      input bit te, input bit th, input bit rr);
    int sz;
    bit pop, ev;
    dct_buffer = d; dct_count = c; test_ending = te; test_has_ended = th; rd_ready = rr;
    @(negedge clk);
    check_outs(ph);
    sz = q.size();
    pop = sz > 0 && rr;
    ev = m_state == 0 && c != m_prev && c != 0;
    m_prev = c;
    if (pop) void'(q.pop_front());
    if (ev) begin
      if (sz == DEPTH && !pop) begin
        m_ovf = 1;
        if (m_drop < 255) m_drop++;
      end else begin
`ifdef OCI_CAPTURE_TIMESTAMP_EN
        q.push_back({m_ts, d});
`else
        q.push_back(d);
`endif
      end
    end
    if (m_state == 0 && (te || th)) m_state = 1;
    else if (m_state == 1 && th && q.size() == 0) m_state = 2;
    @(posedge clk); #1;
    m_ts++;
  endtask
  task automatic async_reset(input string ph);
    @(negedge clk); #2;
    reset_n = 0;
    dct_count = '0; test_ending = 0; test_has_ended = 0; rd_ready = 0;
    #1;
    model_reset();
    check_outs(ph);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1;
  endtask
  initial begin
    int thr[4] = '{2, 8, 5, 0};
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check_outs("reset");
    reset_n = 1;
    step("basic", 30'h1, 4'd1, 0, 0, 1);
    step("basic", 30'h2, 4'd2, 0, 0, 1);
    step("basic", 30'h0, 4'd2, 0, 0, 1);
    step("basic", 30'h0, 4'd2, 0, 0, 1);
    for (int i = 0; i < 5; i++) step("hold", 30'h7 + 30'(i), 4'd3, 0, 0, 0);
    step("hold", 30'h8, 4'd0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("hold", 30'h0, 4'd0, 0, 0, 1);
    for (int i = 0; i < 20; i++) step("ovf", 30'h100 + 30'(i), CNT_W'((i % 15) + 1), 0, 0, 0);
    step("ovf", 30'h3e7, 4'd6, 0, 0, 0);
    step("fullpp", 30'h3e8, 4'd7, 0, 0, 1);
    for (int i = 0; i < 18; i++) step("ovfrd", 30'h0, 4'd7, 0, 0, 1);
    for (int s = 0; s < 4; s++)
      for (int i = 0; i < 100; i++)
        step("rand", DATA_W'($urandom), CNT_W'($urandom_range(0, 3)), 0, 0, $urandom_range(0, 9) < thr[s]);
    async_reset("rst1");
    for (int i = 0; i < 5; i++) step("fill5", 30'h200 + 30'(i), CNT_W'(i + 1), 0, 0, 0);
    async_reset("rstmid");
    step("resume", 30'h300, 4'd1, 0, 0, 0);
    step("resume", 30'h301, 4'd2, 0, 0, 1);
    step("resume", 30'h0, 4'd2, 0, 0, 1);
    step("resume", 30'h0, 4'd2, 0, 0, 1);
    async_reset("rst2");
    step("end", 30'ha, 4'd1, 0, 0, 0);
    step("end", 30'hb, 4'd2, 0, 0, 0);
    step("end", 30'hc, 4'd3, 0, 0, 0);
    step("end", 30'h0, 4'd3, 1, 0, 0);
    step("end", 30'hd, 4'd4, 1, 0, 0);
    step("end", 30'he, 4'd5, 1, 0, 0);
    for (int i = 0; i < 6; i++) step("drain", 30'h0, 4'd5, 0, 1, 1);
    for (int i = 0; i < 3; i++) step("donehold", 30'hf, CNT_W'(i + 6), 0, 0, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
